// File: rtl/junction_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// junction_stream_arbiter_if
// Purpose : bundle of N parallel 8-bit AXI-Stream lanes. The same interface
//           serves the N-wide source side and the single output lane (N=1).
// Signals : tdata  [8*N]  lane k data on [8k+7:8k]
//           tlast  [N]    lane end-of-packet
//           tvalid [N]    lane valid
//           tready [N]    lane ready (driven by the consumer)
// Modports: master - drives data/last/valid, receives ready
//           slave  - receives data/last/valid, drives ready
// ---------------------------------------------------------------------------
interface junction_stream_arbiter_if #(
    parameter int N = 1
);
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tlast;
    logic [N-1:0]   tvalid;
    logic [N-1:0]   tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/junction_stream_arbiter.sv
// ---------------------------------------------------------------------------
// junction_stream_arbiter
// Purpose : shares one registered 8-bit AXI-Stream output between N junction
//           byte streams. Round-robin, packet-atomic arbitration: a grant is
//           held from the first beat until the tlast beat is accepted.
// Ports   : i_clk    clock
//           i_rst    synchronous reset, active high
//           s_src    N-lane source bundle (slave side; tready driven here,
//                    at most one bit set)
//           m_out    single output lane (master side, registered)
//           o_grant  index of the source owning the output
//           o_busy   high while a grant is held
// Config  : define JUNCTION_ARB_HEADER_EN to prefix every output packet with
//           one header byte carrying the granted source index.
// ---------------------------------------------------------------------------
module junction_stream_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    junction_stream_arbiter_if.slave  s_src,
    junction_stream_arbiter_if.master m_out,
    output logic [IDX_W-1:0]          o_grant,
    output logic                      o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PKT  = 2'd2;

    logic [1:0]       state;
    logic             out_free;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             sel_valid;
    logic             found_hi;
    logic             found_lo;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             any_valid;
    logic [IDX_W-1:0] next_grant;
    logic             pkt_load;
    logic             hdr_load;

    // The output register can take a new beat when it is empty or is being
    // drained in this very cycle.
    assign out_free = ~m_out.tvalid[0] | m_out.tready[0];
    assign o_busy   = (state != ST_IDLE);

    // Mux of the currently granted source lane.
    always_comb begin
        sel_data  = 8'd0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (o_grant == IDX_W'(k)) begin
                sel_data  = s_src.tdata[8*k +: 8];
                sel_last  = s_src.tlast[k];
                sel_valid = s_src.tvalid[k];
            end
        end
    end

    // Round-robin search starting just after the last grant: the first valid
    // index above o_grant wins; otherwise wrap and take the first valid index
    // at or below it, so the previous owner is always lowest priority.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (s_src.tvalid[k]) begin
                if (IDX_W'(k) > o_grant) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        hi_idx   = IDX_W'(k);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_idx   = IDX_W'(k);
                end
            end
        end
        any_valid  = found_hi | found_lo;
        next_grant = found_hi ? hi_idx : lo_idx;
    end

    // Only the granted source sees ready, and only while in the packet phase.
    always_comb begin
        s_src.tready = '0;
        for (int k = 0; k < N; k++) begin
            if ((state == ST_PKT) && (o_grant == IDX_W'(k))) begin
                s_src.tready[k] = out_free;
            end
        end
    end

    assign pkt_load = (state == ST_PKT) & sel_valid & out_free;
`ifdef JUNCTION_ARB_HEADER_EN
    assign hdr_load = (state == ST_HDR) & out_free;
`else
    assign hdr_load = 1'b0;
`endif

    // Arbitration FSM plus the registered output stage. A load and a drain
    // in the same cycle keep tvalid high, giving one byte per cycle inside a
    // packet. Reset discards any partial beat without emitting tlast.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_grant      <= IDX_W'(N - 1);
            m_out.tvalid <= '0;
            m_out.tdata  <= '0;
            m_out.tlast  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        o_grant <= next_grant;
`ifdef JUNCTION_ARB_HEADER_EN
                        state   <= ST_HDR;
`else
                        state   <= ST_PKT;
`endif
                    end
                end
                ST_HDR: begin
`ifdef JUNCTION_ARB_HEADER_EN
                    if (hdr_load) begin
                        state <= ST_PKT;
                    end
`else
                    state <= ST_PKT;
`endif
                end
                ST_PKT: begin
                    if (pkt_load && sel_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (hdr_load) begin
                m_out.tdata  <= 8'(o_grant);
                m_out.tlast  <= 1'b0;
                m_out.tvalid <= 1'b1;
            end else if (pkt_load) begin
                m_out.tdata  <= sel_data;
                m_out.tlast  <= sel_last;
                m_out.tvalid <= 1'b1;
            end else if (m_out.tready[0]) begin
                m_out.tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_junction_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_junction_stream_arbiter
// Purpose : self-checking bench for junction_stream_arbiter (N=4). Sources
//           are fed from per-source byte queues; the expected output stream
//           is derived from the round-robin packet order, with a header byte
//           per packet when JUNCTION_ARB_HEADER_EN is defined.
// ---------------------------------------------------------------------------
module tb_junction_stream_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IDX_W-1:0] grant;
    logic             busy;

    junction_stream_arbiter_if #(.N(N)) src_if ();
    junction_stream_arbiter_if #(.N(1)) out_if ();

    junction_stream_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .s_src   (src_if),
        .m_out   (out_if),
        .o_grant (grant),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    // Per-source pending bytes, packet position, and the expected output.
    logic [7:0] src_q [N][$];
    bit         src_l [N][$];
    int         pos [N];
    logic [7:0] exp_d [$];
    bit         exp_l [$];
    int         acc_cyc [$];
    int         model_grant;
    int         gap_pct;
    int         rdy_pct;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            src_l[k].delete();
            pos[k] = 0;
        end
        exp_d.delete();
        exp_l.delete();
        model_grant = N - 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        src_if.tvalid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic add_packet(input int s, input int len, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            src_q[s].push_back(rnd ? 8'($urandom) : base + 8'(i));
            src_l[s].push_back(i == len - 1);
        end
    endtask

    // Expected stream: serve whole packets, always picking the next source
    // after the last one served that still has a packet pending.
    task automatic build_expected();
        int rem [N];
        int off [N];
        int g;
        int pick;
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            off[k] = 0;
            for (int j = 0; j < src_l[k].size(); j++) if (src_l[k][j]) rem[k]++;
        end
        g = model_grant;
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int i = 1; i <= N; i++) begin
                if (pick < 0 && rem[(g + i) % N] > 0) pick = (g + i) % N;
            end
            if (pick >= 0) begin
`ifdef JUNCTION_ARB_HEADER_EN
                exp_d.push_back(8'(pick));
                exp_l.push_back(1'b0);
`endif
                do begin
                    exp_d.push_back(src_q[pick][off[pick]]);
                    exp_l.push_back(src_l[pick][off[pick]]);
                    off[pick]++;
                end while (!src_l[pick][off[pick] - 1]);
                rem[pick]--;
                g = pick;
            end
        end
        model_grant = g;
    endtask

    // Drives sources and sink ready each cycle and checks the DUT. stop_after=0
    // runs until the expected stream is drained; otherwise stops after that many
    // output beats were accepted.
    task automatic run_traffic(input int max_cycles, input int stop_after);
        int  accepted;
        int  n;
        bit  done;
        accepted = 0;
        n = 0;
        done = 1'b0;
        build_expected();
        acc_cyc.delete();
        while (!done && n < max_cycles) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() > 0 && !(pos[k] > 0 && $urandom_range(99) < 32'(gap_pct))) begin
                    src_if.tvalid[k]       = 1'b1;
                    src_if.tdata[8*k +: 8] = src_q[k][0];
                    src_if.tlast[k]        = src_l[k][0];
                end else begin
                    src_if.tvalid[k]       = 1'b0;
                    src_if.tdata[8*k +: 8] = 8'($urandom);
                    src_if.tlast[k]        = 1'($urandom_range(1));
                end
            end
            out_if.tready[0] = ($urandom_range(99) < 32'(rdy_pct));
            #1;
            n_cmp++;
            if ($countones(src_if.tready) > 1) begin
                n_fail++;
                $display("[TB] FAIL tready_onehot: got %b, required at most one bit", src_if.tready);
            end
            for (int k = 0; k < N; k++) begin
                if (src_if.tready[k]) begin
                    n_cmp++;
                    if (grant !== IDX_W'(k) || busy !== 1'b1) begin
                        n_fail++;
                        $display("[TB] FAIL ready_owner: src %0d ready with grant=%0d busy=%b, required grant=%0d busy=1", k, grant, busy, k);
                    end
                    n_cmp++;
                    if (out_if.tvalid[0] && !out_if.tready[0]) begin
                        n_fail++;
                        $display("[TB] FAIL ready_free: src %0d ready=1 while output stalled, required 0", k);
                    end
                end
            end
            if (out_if.tvalid[0] === 1'b1) begin
                n_cmp++;
                if (exp_d.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL out_extra: got beat %h, required no beat", out_if.tdata);
                end else if (out_if.tdata !== exp_d[0] || out_if.tlast[0] !== exp_l[0]) begin
                    n_fail++;
                    $display("[TB] FAIL out_beat: got data=%h last=%b, required data=%h last=%b", out_if.tdata, out_if.tlast[0], exp_d[0], exp_l[0]);
                end
                if (out_if.tready[0]) begin
                    if (exp_d.size() > 0) begin
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                    end
                    accepted++;
                    acc_cyc.push_back(n);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (src_if.tvalid[k] && src_if.tready[k]) begin
                    pos[k] = src_l[k][0] ? 0 : pos[k] + 1;
                    void'(src_q[k].pop_front());
                    void'(src_l[k].pop_front());
                end
            end
            n++;
            done = (stop_after == 0) ? (exp_d.size() == 0) : (accepted >= stop_after);
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL run_timeout: got %0d beats left after %0d cycles, required 0", exp_d.size(), n);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (out_if.tvalid[0] !== 1'b0 || src_if.tready !== '0 || grant !== IDX_W'(N - 1) || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s: got tvalid=%b tready=%b grant=%0d busy=%b, required 0/0000/%0d/0", name, out_if.tvalid[0], src_if.tready, grant, busy, N - 1);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        src_if.tvalid = '1;
        src_if.tlast  = '1;
        src_if.tdata  = 32'hA5A5_A5A5;
        out_if.tready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check_idle("reset_state");
            n_cmp++;
            if (out_if.tdata !== 8'h00 || out_if.tlast[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_data: got data=%h last=%b, required 00/0", out_if.tdata, out_if.tlast[0]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        src_if.tvalid = '0;
        clear_model();
    endtask

    task automatic test_single_packet();
        int exp_n;
`ifdef JUNCTION_ARB_HEADER_EN
        exp_n = 4;
`else
        exp_n = 3;
`endif
        gap_pct = 0;
        rdy_pct = 100;
        add_packet(2, 3, 1'b0, 8'h41);
        run_traffic(50, 0);
        n_cmp++;
        if (grant !== IDX_W'(2)) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got %0d, required 2", grant);
        end
        n_cmp++;
        if (acc_cyc.size() != exp_n) begin
            n_fail++;
            $display("[TB] FAIL single_count: got %0d beats, required %0d", acc_cyc.size(), exp_n);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] != acc_cyc[i-1] + 1) begin
                n_fail++;
                $display("[TB] FAIL single_consecutive: beat %0d at cycle %0d, required %0d", i, acc_cyc[i], acc_cyc[i-1] + 1);
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        gap_pct = 0;
        rdy_pct = 100;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < N; s++) add_packet(s, 2, 1'b0, 8'(16 * s + 4 * p));
        end
        run_traffic(200, 0);
    endtask

    task automatic test_backpressure();
        gap_pct = 0;
        rdy_pct = 50;
        for (int p = 0; p < 12; p++) begin
            add_packet(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)), 1'b1, 8'h00);
        end
        run_traffic(2000, 0);
    endtask

    task automatic test_atomicity();
        apply_reset();
        gap_pct = 0;
        rdy_pct = 100;
        add_packet(0, 2, 1'b0, 8'h10);
        run_traffic(50, 0);
        gap_pct = 60;
        add_packet(1, 4, 1'b0, 8'h20);
        add_packet(0, 2, 1'b0, 8'h30);
        run_traffic(300, 0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        gap_pct = 0;
        rdy_pct = 100;
        add_packet(2, 4, 1'b0, 8'h60);
        run_traffic(50, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_idle("reset_mid_state");
        rst = 1'b0;
        src_if.tvalid = '0;
        clear_model();
        add_packet(2, 2, 1'b0, 8'h70);
        add_packet(0, 3, 1'b0, 8'h80);
        run_traffic(100, 0);
    endtask

    task automatic test_random();
        gap_pct = 30;
        rdy_pct = 70;
        for (int p = 0; p < 20; p++) begin
            add_packet(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)), 1'b1, 8'h00);
        end
        run_traffic(4000, 0);
    endtask

    initial begin
        src_if.tvalid = '0;
        src_if.tlast  = '0;
        src_if.tdata  = '0;
        out_if.tready = 1'b0;
        gap_pct = 0;
        rdy_pct = 100;
        clear_model();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_atomicity();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
